// File: rtl/signed_product_bcd_converter.sv
// Converts a two's-complement product to sign + magnitude BCD using iterative
// double-dabble (one bit per clock) behind valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for a product; in_ready high
// SHIFT | add-3 / shift-left one magnitude bit per clock; busy high
// DONE  | result held on sign/bcd with out_valid high until out_ready
module signed_product_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      Product_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // The digit count must hold the largest magnitude, 2**(WIDTH-1).
    if (10**DIGITS <= 2**(WIDTH-1)) begin : g_digits_too_small
        $error("DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  sign_r;
    logic [WIDTH-1:0]      mag;
    logic [WIDTH-1:0]      mag_shift;
    logic [4*DIGITS-1:0]   bcd_work;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_shift;
    logic [CW-1:0]         cnt;
    logic                  last_shift;

    assign last_shift = (cnt == CW'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_work;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_work[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_work[4*k +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[4*DIGITS-2:0], mag[WIDTH-1]};
        mag_shift = {mag[WIDTH-2:0], 1'b0};
    end

    // Negating the most negative value wraps to 2**(WIDTH-1), which is the
    // correct unsigned magnitude.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_r   <= 1'b0;
            mag      <= '0;
            bcd_work <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            bcd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r   <= Product_in[WIDTH-1];
                        mag      <= Product_in[WIDTH-1] ? (~Product_in + ONE) : Product_in;
                        bcd_work <= '0;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    bcd_work <= bcd_shift;
                    mag      <= mag_shift;
                    cnt      <= cnt + CW'(1);
                    if (last_shift) begin
                        bcd  <= bcd_shift;
                        sign <= sign_r && (bcd_shift != '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_signed_product_bcd_converter.sv
// Directed + random checks of the signed product BCD converter against an
// arithmetic reference model (divide/modulo on the absolute value).
module tb_signed_product_bcd_converter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  Product_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [11:0] bcd;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    signed_product_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Product_in (Product_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sign       (sign),
        .bcd        (bcd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {sign, hundreds, tens, ones}
    function automatic logic [12:0] model(input logic [7:0] p);
        int v;
        int m;
        v = int'(signed'(p));
        m = (v < 0) ? -v : v;
        return {(v < 0), 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " timeout"}, (n < 40), 1);
    endtask

    // Starts at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic convert(input logic [7:0] p, input string tag, input int hold);
        logic [12:0] e;
        int n;
        e = model(p);
        out_ready = 1'b1;
        check({tag, " in_ready"}, in_ready, 1);
        in_valid   = 1'b1;
        Product_in = p;
        @(negedge clk);
        in_valid   = 1'b0;
        Product_in = 8'($urandom);
        check({tag, " busy"}, busy, 1);
        check({tag, " in_ready low"}, in_ready, 0);
        wait_valid(tag, n);
        check({tag, " latency"}, n, 8);
        check({tag, " sign"}, sign, e[12]);
        check({tag, " bcd"}, bcd, e[11:0]);
        if (hold > 0) begin
            out_ready = 1'b0;
            repeat (hold) @(negedge clk);
            check({tag, " held valid"}, out_valid, 1);
            check({tag, " held bcd"}, bcd, e[11:0]);
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, " valid drop"}, out_valid, 0);
        check({tag, " idle ready"}, in_ready, 1);
        check({tag, " kept result"}, {sign, bcd}, e);
    endtask

    initial begin
        int n;
        int seen;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        Product_in = 8'h00;
        repeat (2) @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst sign", sign, 0);
        check("rst bcd", bcd, 12'h000);
        check("rst in_ready", in_ready, 1);
        reset = 1'b0;

        convert(8'd64, "p64", 0);
        convert(8'hC8, "m56", 0);
        convert(8'h00, "zero", 0);
        convert(8'h80, "m128", 0);
        convert(8'h7F, "p127", 0);

        // Back-pressure: held result, ignored in_valid during SHIFT/DONE,
        // and in_valid alongside out_ready not starting a conversion.
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        Product_in = 8'hF9;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid   = 1'b1;
        Product_in = 8'd21;
        wait_valid("m7", n);
        check("m7 sign", sign, 1);
        check("m7 bcd", bcd, 12'h007);
        repeat (5) begin
            @(negedge clk);
            check("m7 hold valid", out_valid, 1);
            check("m7 hold bcd", {sign, bcd}, 13'h1007);
            check("m7 hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("m7 release valid", out_valid, 0);
        check("m7 release busy", busy, 0);
        check("m7 release in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("p21 busy", busy, 1);
        wait_valid("p21", n);
        check("p21 result", {sign, bcd}, 13'h0021);
        @(negedge clk);

        // Reset on the 4th SHIFT cycle aborts the conversion.
        in_valid   = 1'b1;
        Product_in = 8'd99;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort outputs", {sign, bcd}, 13'h0000);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        check("abort no valid", seen, 0);
        convert(8'd99, "p99", 0);

        for (int i = 0; i < 24; i++) begin
            convert(8'($urandom), "rand", int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
